// File: rtl/cnt_checker_if.sv
// Signal bundle between the counter-under-check environment and cnt_checker.
// master drives the sampled counter signals and controls; slave is the checker.
interface cnt_checker_if #(
  parameter int WIDTH = 7,
  parameter int ERR_W = 8
);
  logic             chk_en;
  logic             clr;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_in;
  logic             err;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] wrap_cnt;
  logic [WIDTH-1:0] exp_val;
  logic [1:0]       state;

  modport master (
    output chk_en, clr, cnt_en, cnt_in,
    input  err, err_sticky, err_cnt, wrap_cnt, exp_val, state
  );

  modport slave (
    input  chk_en, clr, cnt_en, cnt_in,
    output err, err_sticky, err_cnt, wrap_cnt, exp_val, state
  );
endinterface

// File: rtl/cnt_checker.sv
// Self-check for an enable-gated up-counter. Each edge rebuilds the expected
// counter value from the previous sample (base_val + base_en) and compares it
// with the current sample. Because the base always follows the observed value,
// one glitched sample produces at most two mismatches.
module cnt_checker #(
  parameter int WIDTH = 7,
  parameter int ERR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cnt_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    RST_CHK = 2'd0,
    IDLE    = 2'd1,
    TRACK   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] base_val_q, base_val_d;
  logic             base_en_q, base_en_d;
  logic [WIDTH-1:0] exp_val_q, exp_cur, exp_nxt;
  logic             err_q, sticky_q;
  logic [ERR_W-1:0] err_cnt_q, wrap_cnt_q;
  logic             cmp, mismatch, wrap_hit, capture;

  // Compare/capture decisions and next base for the current edge.
  always_comb begin
    exp_cur    = base_val_q + {{(WIDTH-1){1'b0}}, base_en_q};
    // RST_CHK compares against 0; the base is cleared by reset so exp_cur is 0.
    cmp        = bus.chk_en && ((state_q == RST_CHK) || (state_q == TRACK));
    mismatch   = cmp && (bus.cnt_in != exp_cur);
    wrap_hit   = cmp && base_en_q && (&base_val_q) && (bus.cnt_in == '0);
    // RST_CHK always captures; IDLE/TRACK capture only while checking.
    capture    = (state_q == RST_CHK) || bus.chk_en;
    base_val_d = capture ? bus.cnt_in : base_val_q;
    base_en_d  = capture ? bus.cnt_en : base_en_q;
    exp_nxt    = base_val_d + {{(WIDTH-1){1'b0}}, base_en_d};
    state_d    = state_q;
    case (state_q)
      RST_CHK: state_d = bus.chk_en ? TRACK : IDLE;
      IDLE:    state_d = bus.chk_en ? TRACK : IDLE;
      TRACK:   state_d = bus.chk_en ? TRACK : IDLE;
      default: state_d = RST_CHK;
    endcase
  end

  // State, base, and registered status outputs; clr wins over same-edge updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RST_CHK;
      base_val_q <= '0;
      base_en_q  <= 1'b0;
      exp_val_q  <= '0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_val_q <= base_val_d;
      base_en_q  <= base_en_d;
      exp_val_q  <= exp_nxt;
      err_q      <= mismatch;
      if (bus.clr) begin
        sticky_q   <= 1'b0;
        err_cnt_q  <= '0;
        wrap_cnt_q <= '0;
      end else begin
        if (mismatch) sticky_q <= 1'b1;
        if (mismatch && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        if (wrap_hit && (wrap_cnt_q != '1)) wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
    end
  end

  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.wrap_cnt   = wrap_cnt_q;
  assign bus.exp_val    = exp_val_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_cnt_checker.sv
// Directed table-driven bench for cnt_checker plus long wrap/saturation runs.
module tb_cnt_checker;
  localparam int WIDTH = 7;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cnt_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  cnt_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       chk;
    logic       clr;
    logic       en;
    logic [6:0] cin;
    logic       err;
    logic       stk;
    logic [7:0] ecnt;
    logic [7:0] wcnt;
    logic [6:0] expv;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [28];

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic cl,
                      input logic e, input logic [6:0] ci);
    rst_n      = r;
    bus.chk_en = c;
    bus.clr    = cl;
    bus.cnt_en = e;
    bus.cnt_in = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic       err_seen;
    logic [6:0] cnt;
    //        rst chk clr en  cin  | err stk ecnt wcnt expv st
    tbl[0]  = '{0, 1, 0, 0,   0,     0, 0,  0, 0,   0, 0}; // reset
    tbl[1]  = '{1, 1, 0, 1,   0,     0, 0,  0, 0,   1, 2}; // post-reset compare with 0
    tbl[2]  = '{1, 1, 0, 1,   1,     0, 0,  0, 0,   2, 2};
    tbl[3]  = '{1, 1, 0, 1,   2,     0, 0,  0, 0,   3, 2};
    tbl[4]  = '{1, 1, 0, 1,   3,     0, 0,  0, 0,   4, 2};
    tbl[5]  = '{1, 1, 0, 1,   4,     0, 0,  0, 0,   5, 2};
    tbl[6]  = '{1, 1, 0, 1,   5,     0, 0,  0, 0,   6, 2};
    tbl[7]  = '{1, 1, 0, 1,   9,     1, 1,  1, 0,  10, 2}; // glitch 9 vs 6
    tbl[8]  = '{1, 1, 0, 1,   7,     1, 1,  2, 0,   8, 2}; // 7 vs 10
    tbl[9]  = '{1, 1, 0, 1,   8,     0, 1,  2, 0,   9, 2}; // resynced
    tbl[10] = '{1, 1, 0, 0,   9,     0, 1,  2, 0,   9, 2}; // hold captured
    tbl[11] = '{1, 1, 0, 1,   9,     0, 1,  2, 0,  10, 2}; // held value ok
    tbl[12] = '{1, 1, 1, 1,  10,     0, 0,  0, 0,  11, 2}; // clr
    tbl[13] = '{1, 0, 0, 1,  11,     0, 0,  0, 0,  11, 1}; // pause, base kept
    tbl[14] = '{1, 0, 0, 1,  20,     0, 0,  0, 0,  11, 1};
    tbl[15] = '{1, 0, 0, 1,  50,     0, 0,  0, 0,  11, 1};
    tbl[16] = '{1, 1, 0, 1,  50,     0, 0,  0, 0,  51, 2}; // resync only
    tbl[17] = '{1, 1, 0, 1,  51,     0, 0,  0, 0,  52, 2};
    tbl[18] = '{1, 1, 1, 1,  99,     1, 0,  0, 0, 100, 2}; // clr beats mismatch
    tbl[19] = '{1, 1, 0, 1, 100,     0, 0,  0, 0, 101, 2};
    tbl[20] = '{0, 1, 0, 1, 101,     0, 0,  0, 0,   0, 0}; // mid-run reset
    tbl[21] = '{1, 1, 0, 1,   3,     1, 1,  1, 0,   4, 2}; // bad post-reset value
    tbl[22] = '{1, 1, 0, 1,   4,     0, 1,  1, 0,   5, 2};
    tbl[23] = '{0, 0, 0, 0,   0,     0, 0,  0, 0,   0, 0};
    tbl[24] = '{1, 0, 0, 1,   0,     0, 0,  0, 0,   1, 1}; // RST_CHK -> IDLE
    tbl[25] = '{1, 1, 0, 1,   5,     0, 0,  0, 0,   6, 2}; // resync from IDLE
    tbl[26] = '{1, 1, 0, 0,   6,     0, 0,  0, 0,   6, 2};
    tbl[27] = '{1, 1, 0, 1,   6,     0, 0,  0, 0,   7, 2};

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].rst, tbl[i].chk, tbl[i].clr, tbl[i].en, tbl[i].cin);
      cmp("err",        i, int'(bus.err),        int'(tbl[i].err));
      cmp("err_sticky", i, int'(bus.err_sticky), int'(tbl[i].stk));
      cmp("err_cnt",    i, int'(bus.err_cnt),    int'(tbl[i].ecnt));
      cmp("wrap_cnt",   i, int'(bus.wrap_cnt),   int'(tbl[i].wcnt));
      cmp("exp_val",    i, int'(bus.exp_val),    int'(tbl[i].expv));
      cmp("state",      i, int'(bus.state),      int'(tbl[i].st));
    end

    // Correct counter for 130 enabled edges: exactly one 127->0 wrap.
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    cnt = 7'd0;
    err_seen = 1'b0;
    for (int i = 0; i < 130; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, cnt);
      if (bus.err) err_seen = 1'b1;
      cnt = cnt + 7'd1;
    end
    cmp("wrap_run_wrap_cnt", 130, int'(bus.wrap_cnt), 1);
    cmp("wrap_run_err_cnt",  130, int'(bus.err_cnt),  0);
    cmp("wrap_run_err_seen", 130, int'(err_seen),     0);
    cmp("wrap_run_exp_val",  130, int'(bus.exp_val),  2);

    // Stuck-at-0 counter with enable high: 299 mismatches saturate at 255.
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 7'd0);
    cmp("sat_err_cnt",    300, int'(bus.err_cnt),    255);
    cmp("sat_err_sticky", 300, int'(bus.err_sticky), 1);
    cmp("sat_wrap_cnt",   300, int'(bus.wrap_cnt),   0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 7'd0);
    cmp("sat_clr_err_cnt", 301, int'(bus.err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
